// File: rtl/seqdet_pkg.sv
// Shared constants for the serial pattern detector: default pattern and the
// fill-state encoding that benches use to decode history occupancy.
package seqdet_pkg;

  localparam logic [3:0] SEQDET_PAT_DEFAULT = 4'b1011;

  typedef enum logic [1:0] {
    FILL_EMPTY = 2'd0,
    FILL_PART  = 2'd1,
    FILL_FULL  = 2'd2
  } fill_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts INC pulses and parks at all-ones.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          C,
  input  logic          R,
  input  logic          INC,
  output logic [CW-1:0] Q
);

  logic [CW-1:0] r_q;

  always_ff @(posedge C) begin
    if (R) begin
      r_q <= '0;
    end else if (INC && (r_q != {CW{1'b1}})) begin
      r_q <= r_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector with N-bit history and registered match pulse.
// Define SEQDET_COUNT_EN to build the CNT port and saturating match counter.
module seq_detect
  import seqdet_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = N'(SEQDET_PAT_DEFAULT),
  parameter bit             OVERLAP = 1'b1,
  parameter int             CW      = 8
) (
  input  logic          C,
  input  logic          R,
  input  logic          EN,
  input  logic          D,
  output logic          M,
  output logic [N-1:0]  HIST,
  output logic          FULL
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CW-1:0] CNT
`endif
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(N);

  logic [N-1:0]  r_hist;
  logic [FW-1:0] r_fill;
  logic          r_m;

  logic [N-1:0]  w_nh;
  logic [FW-1:0] w_nf;
  logic          w_hit;
  logic [N-1:0]  w_hist_nxt;
  logic [FW-1:0] w_fill_nxt;
  logic          w_m_nxt;
  fill_state_t   w_state;

  // The fill count is the state register; EMPTY/PART/FULL are decoded from it.
  always_ff @(posedge C) begin
    if (R) begin
      r_hist <= '0;
      r_fill <= '0;
      r_m    <= 1'b0;
    end else begin
      r_hist <= w_hist_nxt;
      r_fill <= w_fill_nxt;
      r_m    <= w_m_nxt;
    end
  end

  always_comb begin
    w_nh       = {r_hist[N-2:0], D};
    w_nf       = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + {{(FW-1){1'b0}}, 1'b1};
    w_hit      = (w_nf == FILL_MAX) && (w_nh == PATTERN);
    w_hist_nxt = r_hist;
    w_fill_nxt = r_fill;
    w_m_nxt    = 1'b0;
    if (EN) begin
      w_hist_nxt = w_nh;
      w_m_nxt    = w_hit;
      // Non-overlap restarts occupancy only; old history bits stay visible.
      w_fill_nxt = (w_hit && !OVERLAP) ? '0 : w_nf;
    end
  end

  always_comb begin
    w_state = FILL_PART;
    if (r_fill == '0) begin
      w_state = FILL_EMPTY;
    end else if (r_fill == FILL_MAX) begin
      w_state = FILL_FULL;
    end
  end

  assign M    = r_m;
  assign HIST = r_hist;
  assign FULL = (w_state == FILL_FULL);

`ifdef SEQDET_COUNT_EN
  sat_counter #(.CW(CW)) u_cnt (
    .C   (C),
    .R   (R),
    .INC (EN & w_hit),
    .Q   (CNT)
  );
`endif

endmodule

// File: tb/tb_seq_detect.sv
// Self-checking bench for seq_detect: vector table, corner sequences and
// random stimulus against a bit-list reference model.
module tb_seq_detect;

  logic clk = 1'b0;
  logic rst, en, d;
  always #5 clk = ~clk;

  logic       m_ov, m_nov, m_sat;
  logic [3:0] hist_ov, hist_nov, hist_sat;
  logic       full_ov, full_nov, full_sat;
`ifdef SEQDET_COUNT_EN
  logic [7:0] cnt_ov, cnt_nov;
  logic [1:0] cnt_sat;
`endif

  seq_detect #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CW(8)) u_ov (
    .C(clk), .R(rst), .EN(en), .D(d), .M(m_ov), .HIST(hist_ov), .FULL(full_ov)
`ifdef SEQDET_COUNT_EN
    , .CNT(cnt_ov)
`endif
  );

  seq_detect #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CW(8)) u_nov (
    .C(clk), .R(rst), .EN(en), .D(d), .M(m_nov), .HIST(hist_nov), .FULL(full_nov)
`ifdef SEQDET_COUNT_EN
    , .CNT(cnt_nov)
`endif
  );

  seq_detect #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CW(2)) u_sat (
    .C(clk), .R(rst), .EN(en), .D(d), .M(m_sat), .HIST(hist_sat), .FULL(full_sat)
`ifdef SEQDET_COUNT_EN
    , .CNT(cnt_sat)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: instance 0 overlap, 1 and 2 non-overlap; 2 saturates at 3.
  int hist_m;
  int valid_m [3];
  int m_m     [3];
  int cnt_m   [3];
  int ovl_m   [3] = '{1, 0, 0};
  int cmax_m  [3] = '{255, 255, 3};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r_i, input logic en_i, input logic d_i);
    if (r_i) begin
      hist_m = 0;
      for (int i = 0; i < 3; i++) begin
        valid_m[i] = 0; m_m[i] = 0; cnt_m[i] = 0;
      end
    end else if (!en_i) begin
      for (int i = 0; i < 3; i++) m_m[i] = 0;
    end else begin
      hist_m = ((hist_m * 2) + int'(d_i)) % 16;
      for (int i = 0; i < 3; i++) begin
        valid_m[i]++;
        m_m[i] = (valid_m[i] >= 4 && hist_m == 11) ? 1 : 0;
        if (m_m[i] == 1) begin
          if (cnt_m[i] < cmax_m[i]) cnt_m[i]++;
          if (ovl_m[i] == 0) valid_m[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("ov_m", int'(m_ov), m_m[0]);
    chk("nov_m", int'(m_nov), m_m[1]);
    chk("sat_m", int'(m_sat), m_m[2]);
    chk("ov_hist", int'(hist_ov), hist_m);
    chk("nov_hist", int'(hist_nov), hist_m);
    chk("sat_hist", int'(hist_sat), hist_m);
    chk("ov_full", int'(full_ov), (valid_m[0] >= 4) ? 1 : 0);
    chk("nov_full", int'(full_nov), (valid_m[1] >= 4) ? 1 : 0);
    chk("sat_full", int'(full_sat), (valid_m[2] >= 4) ? 1 : 0);
`ifdef SEQDET_COUNT_EN
    chk("ov_cnt", int'(cnt_ov), cnt_m[0]);
    chk("nov_cnt", int'(cnt_nov), cnt_m[1]);
    chk("sat_cnt", int'(cnt_sat), cnt_m[2]);
`endif
  endtask

  task automatic step(input logic r_i, input logic en_i, input logic d_i);
    rst = r_i; en = en_i; d = d_i;
    @(posedge clk);
    #1;
    model_step(r_i, en_i, d_i);
    compare_all();
  endtask

  typedef struct {
    logic       r, e, b;
    logic       m_ov, m_nov;
    logic [3:0] hist;
    logic       f_ov, f_nov;
  } vec_t;

  function automatic vec_t mk(logic r_i, logic e_i, logic b_i, logic mo, logic mn,
                              logic [3:0] h, logic fo, logic fn);
    vec_t v;
    v.r = r_i; v.e = e_i; v.b = b_i; v.m_ov = mo; v.m_nov = mn;
    v.hist = h; v.f_ov = fo; v.f_nov = fn;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    logic [3:0] pat;
    int         sat_exp [5] = '{1, 2, 3, 3, 3};

    rst = 1'b1; en = 1'b1; d = 1'b1;
    hist_m = 0;
    for (int i = 0; i < 3; i++) begin
      valid_m[i] = 0; m_m[i] = 0; cnt_m[i] = 0;
    end

    // reset, basic match, overlap vs restart
    tbl.push_back(mk(1, 1, 1, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0101, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 4'b1011, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'b0110, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'b1101, 1, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 4'b1011, 1, 0));
    // enable gap
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0101, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 4'b1011, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4'b1011, 1, 0));
    // reset mid-stream
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'b0010, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0101, 0, 0));
    tbl.push_back(mk(1, 1, 1, 0, 0, 4'b0000, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 4'b0001, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].r, tbl[k].e, tbl[k].b);
      chk($sformatf("tbl%0d_m_ov", k), int'(m_ov), int'(tbl[k].m_ov));
      chk($sformatf("tbl%0d_m_nov", k), int'(m_nov), int'(tbl[k].m_nov));
      chk($sformatf("tbl%0d_hist", k), int'(hist_ov), int'(tbl[k].hist));
      chk($sformatf("tbl%0d_full_ov", k), int'(full_ov), int'(tbl[k].f_ov));
      chk($sformatf("tbl%0d_full_nov", k), int'(full_nov), int'(tbl[k].f_nov));
    end

    // saturation on the 2-bit counter instance
    pat = 4'b1011;
    step(1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      for (int b = 0; b < 4; b++) step(0, 1, pat[3-b]);
      chk($sformatf("satseq%0d_m", k), int'(m_sat), 1);
`ifdef SEQDET_COUNT_EN
      chk($sformatf("satseq%0d_cnt", k), int'(cnt_sat), sat_exp[k]);
`endif
    end
    step(0, 0, 1);
    chk("satseq_m_drop", int'(m_sat), 0);
`ifdef SEQDET_COUNT_EN
    chk("satseq_cnt_hold", int'(cnt_sat), 3);
`endif

    // random stream against the model
    step(1, 0, 0);
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
